// File: rtl/trace_reader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trace_reader_pkg
// Purpose  : Fixed-point formats, column-buffer geometry and record types
//            shared by the trace-buffer consumer and its divider.
// Revision : 1.0 - initial release
// ============================================================================
package trace_reader_pkg;

    localparam int c_VDIST_INT  = 7;
    localparam int c_VDIST_FRAC = 9;
    localparam int c_VDIST_W    = c_VDIST_INT + c_VDIST_FRAC;   // UQ7.9
    localparam int c_HEIGHT_W   = 9;
    localparam int c_QUOT_W     = 17;
    localparam int c_TEX_W      = 6;
    localparam int c_COL_W      = 10;
    localparam int c_POS_W      = 10;
    localparam int c_COL_BASE   = 64;
    localparam int c_NUM_COLS   = 512;
    localparam int c_IDX_W      = $clog2(c_NUM_COLS);

    typedef struct packed {
        logic                  side;
        logic [c_TEX_W-1:0]    tex;
        logic [c_HEIGHT_W-1:0] height;
    } col_entry_t;

    typedef struct packed {
        logic [c_IDX_W-1:0]   idx;
        logic                 side;
        logic [c_TEX_W-1:0]   tex;
        logic [c_VDIST_W-1:0] vdist;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_WRITE = 2'd2
    } div_state_t;

    function automatic logic [c_HEIGHT_W-1:0] sat_height(
        input logic [c_QUOT_W-1:0]   quot,
        input logic [c_HEIGHT_W-1:0] hmax
    );
        logic [c_HEIGHT_W-1:0] h;
        h = (quot > {{(c_QUOT_W-c_HEIGHT_W){1'b0}}, hmax}) ? hmax : quot[c_HEIGHT_W-1:0];
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_divider
// Purpose  : Unsigned N-bit restoring divider, one quotient bit per clock,
//            start/done handshake. The first bit is resolved in the start cycle.
// Revision : 1.0 - initial release
// ============================================================================
module serial_divider #(
    parameter int N = 17,
    parameter int D = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [N-1:0] i_num,
    input  logic [D-1:0] i_den,
    output logic         o_done,
    output logic [N-1:0] o_quot
);

    localparam int c_CNT_W = $clog2(N);

    logic [D-1:0]       r_rem;
    logic [D-1:0]       r_den;
    logic [N-1:0]       r_quot;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [D-1:0] w_rem_in;
    logic [D-1:0] w_den;
    logic [N-1:0] w_q_in;
    logic [D:0]   w_shift;
    logic         w_ge;
    logic [D-1:0] w_rem_nxt;
    logic [N-1:0] w_q_nxt;

    // Operands come straight from the inputs on start so no cycle is lost loading.
    always_comb begin
        w_rem_in  = i_start ? '0    : r_rem;
        w_q_in    = i_start ? i_num : r_quot;
        w_den     = i_start ? i_den : r_den;
        w_shift   = {w_rem_in, w_q_in[N-1]};
        w_ge      = (w_shift >= {1'b0, w_den});
        w_rem_nxt = w_ge ? D'(w_shift - {1'b0, w_den}) : w_shift[D-1:0];
        w_q_nxt   = {w_q_in[N-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= w_rem_nxt;
                r_quot <= w_q_nxt;
                r_den  <= i_den;
                r_cnt  <= c_CNT_W'(N - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_rem_nxt;
                r_quot <= w_q_nxt;
                r_cnt  <= r_cnt - 1'b1;
                if (r_cnt == c_CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_quot = r_quot;

endmodule
`default_nettype wire

// File: rtl/trace_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : trace_reader
// Purpose  : Queues tracer hit records, turns distance into wall half-height
//            and serves a registered per-pixel wall/sky/floor lookup.
// Revision : 1.0 - initial release
// ============================================================================
module trace_reader
    import trace_reader_pkg::*;
#(
    parameter int H_NUM    = 122880,
    parameter int H_MAX    = 511,
    parameter int COL_BASE = c_COL_BASE,
    parameter int V_MID    = 240,
    parameter int QDEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  store,
    input  logic [c_COL_W-1:0]    column,
    input  logic                  side,
    input  logic [c_VDIST_W-1:0]  vdist,
    input  logic [c_TEX_W-1:0]    tex,
    input  logic [c_POS_W-1:0]    hpos,
    input  logic [c_POS_W-1:0]    vpos,
    output logic                  px_wall,
    output logic                  px_floor,
    output logic                  px_side,
    output logic [c_TEX_W-1:0]    px_texu,
    output logic [c_POS_W-1:0]    px_wally,
    output logic [c_HEIGHT_W-1:0] px_height,
    output logic                  in_range,
    output logic                  overflow,
    output logic                  busy
);

    localparam int                      c_QP_W   = $clog2(QDEPTH);
    localparam logic [c_COL_W-1:0]      c_COL_LO = c_COL_W'(COL_BASE);
    localparam logic [c_COL_W-1:0]      c_COL_HI = c_COL_W'(COL_BASE + c_NUM_COLS - 1);
    localparam logic [c_POS_W-1:0]      c_VMID   = c_POS_W'(V_MID);
    localparam logic signed [10:0]      c_VMID_S = 11'(V_MID);
    localparam logic [c_HEIGHT_W-1:0]   c_HMAX   = c_HEIGHT_W'(H_MAX);
    localparam logic [c_QUOT_W-1:0]     c_HNUM   = c_QUOT_W'(H_NUM);

    // ---------------------------------------------------------------- queue
    trace_rec_t        r_q [QDEPTH];
    logic [c_QP_W:0]   r_wr_ptr;
    logic [c_QP_W:0]   r_rd_ptr;
    logic              r_overflow;

    logic              w_q_empty;
    logic              w_q_full;
    logic              w_col_ok;
    logic              w_store_ok;
    logic              w_push;
    logic              w_pop;
    trace_rec_t        w_new_rec;
    trace_rec_t        w_head;

    // ----------------------------------------------------------- divider FSM
    div_state_t              r_state;
    logic [c_IDX_W-1:0]      r_idx;
    logic                    r_side;
    logic [c_TEX_W-1:0]      r_tex;
    logic                    r_zero;
    logic                    w_div_start;
    logic                    w_div_done;
    logic [c_QUOT_W-1:0]     w_div_quot;
    col_entry_t              w_wr_entry;

    // --------------------------------------------------------- column buffer
    col_entry_t              r_mem [c_NUM_COLS];

    // ------------------------------------------------------------- read side
    logic                    w_hpos_ok;
    logic [c_IDX_W-1:0]      w_rd_idx;
    col_entry_t              w_rd_entry;
    logic signed [10:0]      w_top;
    logic signed [10:0]      w_bot;
    logic signed [10:0]      w_vs;
    logic                    w_wall;
    logic                    w_floor;
    logic [c_POS_W-1:0]      w_wally;

    logic                    r_px_wall;
    logic                    r_px_floor;
    logic                    r_px_side;
    logic [c_TEX_W-1:0]      r_px_texu;
    logic [c_POS_W-1:0]      r_px_wally;
    logic [c_HEIGHT_W-1:0]   r_px_height;
    logic                    r_in_range;

    always_comb begin
        w_q_empty        = (r_wr_ptr == r_rd_ptr);
        w_q_full         = ((r_wr_ptr - r_rd_ptr) == (c_QP_W+1)'(QDEPTH));
        w_col_ok         = (column >= c_COL_LO) && (column <= c_COL_HI);
        w_store_ok       = store && w_col_ok;
        w_head           = r_q[r_rd_ptr[c_QP_W-1:0]];
        w_pop            = (r_state == ST_IDLE) && !w_q_empty;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        w_push           = w_store_ok && (!w_q_full || w_pop);
        w_new_rec.idx    = c_IDX_W'(column - c_COL_LO);
        w_new_rec.side   = side;
        w_new_rec.tex    = tex;
        w_new_rec.vdist  = vdist;
        w_div_start      = w_pop && (w_head.vdist != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_store_ok && w_q_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_wr_ptr[c_QP_W-1:0]] <= w_new_rec;
        end
    end

    serial_divider #(
        .N (c_QUOT_W),
        .D (c_VDIST_W)
    ) u_div (
        .clk     (clk),
        .rst     (reset),
        .i_start (w_div_start),
        .i_num   (c_HNUM),
        .i_den   (w_head.vdist),
        .o_done  (w_div_done),
        .o_quot  (w_div_quot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_side  <= 1'b0;
            r_tex   <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_q_empty) begin
                        r_idx   <= w_head.idx;
                        r_side  <= w_head.side;
                        r_tex   <= w_head.tex;
                        r_zero  <= (w_head.vdist == '0);
                        r_state <= (w_head.vdist == '0) ? ST_WRITE : ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_wr_entry.side   = r_side;
        w_wr_entry.tex    = r_tex;
        w_wr_entry.height = r_zero ? c_HMAX : sat_height(w_div_quot, c_HMAX);
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_WRITE) begin
            r_mem[r_idx] <= w_wr_entry;
        end
    end

    // Signed compare lets a half-height above the horizon row clip to screen top.
    always_comb begin
        w_hpos_ok  = (hpos >= c_COL_LO) && (hpos <= c_COL_HI);
        w_rd_idx   = c_IDX_W'(hpos - c_COL_LO);
        w_rd_entry = r_mem[w_rd_idx];
        w_top      = c_VMID_S - $signed({2'b00, w_rd_entry.height});
        w_bot      = c_VMID_S + $signed({2'b00, w_rd_entry.height});
        w_vs       = $signed({1'b0, vpos});
        w_wall     = (w_vs >= w_top) && (w_vs < w_bot);
        w_floor    = !w_wall && (vpos >= c_VMID);
        w_wally    = vpos - c_VMID + {1'b0, w_rd_entry.height};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_px_wall   <= 1'b0;
            r_px_floor  <= 1'b0;
            r_px_side   <= 1'b0;
            r_px_texu   <= '0;
            r_px_wally  <= '0;
            r_px_height <= '0;
            r_in_range  <= 1'b0;
        end else begin
            r_in_range <= w_hpos_ok;
            if (w_hpos_ok) begin
                r_px_wall   <= w_wall;
                r_px_floor  <= w_floor;
                r_px_side   <= w_rd_entry.side;
                r_px_texu   <= w_rd_entry.tex;
                r_px_wally  <= w_wally;
                r_px_height <= w_rd_entry.height;
            end else begin
                r_px_wall   <= 1'b0;
                r_px_floor  <= 1'b0;
                r_px_side   <= 1'b0;
                r_px_texu   <= '0;
                r_px_wally  <= '0;
                r_px_height <= '0;
            end
        end
    end

    assign px_wall   = r_px_wall;
    assign px_floor  = r_px_floor;
    assign px_side   = r_px_side;
    assign px_texu   = r_px_texu;
    assign px_wally  = r_px_wally;
    assign px_height = r_px_height;
    assign in_range  = r_in_range;
    assign overflow  = r_overflow;
    assign busy      = !w_q_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire
